// File: rtl/demux1_4.sv
// rtl/demux1_4.sv - registered 1-to-4 demultiplexer; DEMUX_ACT_CNT_EN adds per-channel activity counters
module demux1_4 #(
  parameter int WIDTH      = 1,
  parameter bit HOLD_UNSEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_sel
`ifdef DEMUX_ACT_CNT_EN
  ,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1,
  output logic [7:0]       cnt2,
  output logic [7:0]       cnt3
`endif
);

  logic [WIDTH-1:0] y_q [4];
  logic [WIDTH-1:0] y_d [4];
  logic [3:0]       y_sel_q;
  logic [3:0]       y_sel_d;

  // Route a to the selected channel; unselected channels clear or hold by policy
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      y_d[i] = HOLD_UNSEL ? y_q[i] : '0;
    end
    y_d[sel] = a;
    y_sel_d  = 4'b0001 << sel;
  end

  // Output registers; reset wins over any select/data activity
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        y_q[i] <= '0;
      end
      y_sel_q <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        y_q[i] <= y_d[i];
      end
      y_sel_q <= y_sel_d;
    end
  end

  assign y0    = y_q[0];
  assign y1    = y_q[1];
  assign y2    = y_q[2];
  assign y3    = y_q[3];
  assign y_sel = y_sel_q;

`ifdef DEMUX_ACT_CNT_EN
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];

  // Count non-zero payloads on the selected channel, sticking at 8'hFF
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if ((a != '0) && (cnt_q[sel] != 8'hFF)) begin
      cnt_d[sel] = cnt_q[sel] + 8'd1;
    end
  end

  // Counter registers, cleared together on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux1_4.sv
// tb/tb_demux1_4.sv - directed table-driven bench for demux1_4 (clear, hold and 8-bit variants)
module tb_demux1_4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [1:0] sel_c = 2'd0;
  logic       a_c   = 1'b0;
  logic       y0_c, y1_c, y2_c, y3_c;
  logic [3:0] ys_c;

  logic [1:0] sel_h = 2'd0;
  logic       a_h   = 1'b0;
  logic       y0_h, y1_h, y2_h, y3_h;
  logic [3:0] ys_h;

  logic [1:0] sel_w = 2'd0;
  logic [7:0] a_w   = 8'd0;
  logic [7:0] y0_w, y1_w, y2_w, y3_w;
  logic [3:0] ys_w;

`ifdef DEMUX_ACT_CNT_EN
  logic [7:0] c0_c, c1_c, c2_c, c3_c;
  logic [7:0] c0_h, c1_h, c2_h, c3_h;
  logic [7:0] c0_w, c1_w, c2_w, c3_w;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  demux1_4 #(.WIDTH(1), .HOLD_UNSEL(1'b0)) u_clr (
    .clk(clk), .rst(rst), .sel(sel_c), .a(a_c),
    .y0(y0_c), .y1(y1_c), .y2(y2_c), .y3(y3_c), .y_sel(ys_c)
`ifdef DEMUX_ACT_CNT_EN
    , .cnt0(c0_c), .cnt1(c1_c), .cnt2(c2_c), .cnt3(c3_c)
`endif
  );

  demux1_4 #(.WIDTH(1), .HOLD_UNSEL(1'b1)) u_hold (
    .clk(clk), .rst(rst), .sel(sel_h), .a(a_h),
    .y0(y0_h), .y1(y1_h), .y2(y2_h), .y3(y3_h), .y_sel(ys_h)
`ifdef DEMUX_ACT_CNT_EN
    , .cnt0(c0_h), .cnt1(c1_h), .cnt2(c2_h), .cnt3(c3_h)
`endif
  );

  demux1_4 #(.WIDTH(8), .HOLD_UNSEL(1'b0)) u_w8 (
    .clk(clk), .rst(rst), .sel(sel_w), .a(a_w),
    .y0(y0_w), .y1(y1_w), .y2(y2_w), .y3(y3_w), .y_sel(ys_w)
`ifdef DEMUX_ACT_CNT_EN
    , .cnt0(c0_w), .cnt1(c1_w), .cnt2(c2_w), .cnt3(c3_w)
`endif
  );

  typedef struct {
    logic       rst;
    logic [1:0] sel;
    logic       a;
    logic [3:0] exp_y;   // {y3,y2,y1,y0}
    logic [3:0] exp_ys;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset held two edges with sel=2,a=1, then release with same inputs
    vecs.push_back('{1'b1, 2'd2, 1'b1, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 2'd2, 1'b1, 4'b0000, 4'b0000});
    vecs.push_back('{1'b0, 2'd2, 1'b1, 4'b0100, 4'b0100});
    // exhaustive sweep: a=0 then a=1 for each sel
    vecs.push_back('{1'b0, 2'd0, 1'b0, 4'b0000, 4'b0001});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 4'b0001, 4'b0001});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 4'b0000, 4'b0010});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 4'b0010, 4'b0010});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 4'b0000, 4'b0100});
    vecs.push_back('{1'b0, 2'd2, 1'b1, 4'b0100, 4'b0100});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 4'b0000, 4'b1000});
    vecs.push_back('{1'b0, 2'd3, 1'b1, 4'b1000, 4'b1000});
    // mid-stream reset clears, next edge loads normally
    vecs.push_back('{1'b1, 2'd3, 1'b1, 4'b0000, 4'b0000});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 4'b0010, 4'b0010});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 4'b0001, 4'b0001});

    #1;
    foreach (vecs[i]) begin
      rst   = vecs[i].rst;
      sel_c = vecs[i].sel;
      a_c   = vecs[i].a;
      tick();
      chk($sformatf("vec%0d_y", i), {28'd0, y3_c, y2_c, y1_c, y0_c}, {28'd0, vecs[i].exp_y});
      chk($sformatf("vec%0d_ysel", i), {28'd0, ys_c}, {28'd0, vecs[i].exp_ys});
    end

    // latency: y0=1 now; switch to sel=3 and confirm nothing moves before the edge
    sel_c = 2'd3;
    a_c   = 1'b1;
    #2;
    chk("lat_pre_y", {28'd0, y3_c, y2_c, y1_c, y0_c}, 32'b0001);
    chk("lat_pre_ysel", {28'd0, ys_c}, 32'b0001);
    tick();
    chk("lat_post_y", {28'd0, y3_c, y2_c, y1_c, y0_c}, 32'b1000);
    chk("lat_post_ysel", {28'd0, ys_c}, 32'b1000);

    // hold policy
    rst = 1'b1;
    tick();
    chk("hold_rst", {28'd0, y3_h, y2_h, y1_h, y0_h}, 32'b0000);
    rst = 1'b0; sel_h = 2'd1; a_h = 1'b1;
    tick();
    chk("hold_w1", {28'd0, y3_h, y2_h, y1_h, y0_h}, 32'b0010);
    sel_h = 2'd2; a_h = 1'b1;
    tick();
    chk("hold_w2", {28'd0, y3_h, y2_h, y1_h, y0_h}, 32'b0110);
    chk("hold_w2_ysel", {28'd0, ys_h}, 32'b0100);
    sel_h = 2'd3; a_h = 1'b0;
    tick();
    chk("hold_w3_zero", {28'd0, y3_h, y2_h, y1_h, y0_h}, 32'b0110);
    chk("hold_w3_ysel", {28'd0, ys_h}, 32'b1000);
    rst = 1'b1;
    tick();
    chk("hold_rst2", {28'd0, y3_h, y2_h, y1_h, y0_h}, 32'b0000);
    chk("hold_rst2_ysel", {28'd0, ys_h}, 32'b0000);

    // 8-bit data path
    rst = 1'b0; sel_w = 2'd1; a_w = 8'hA5;
    tick();
    chk("w8_y1", {24'd0, y1_w}, 32'hA5);
    chk("w8_others", {y3_w, y2_w, y0_w, 8'd0}, 32'd0);
    sel_w = 2'd3; a_w = 8'h3C;
    tick();
    chk("w8_y3", {24'd0, y3_w}, 32'h3C);
    chk("w8_y1_clr", {24'd0, y1_w}, 32'h00);
    chk("w8_ysel", {28'd0, ys_w}, 32'b1000);

`ifdef DEMUX_ACT_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0; sel_c = 2'd0; a_c = 1'b1;
    for (int i = 0; i < 254; i++) tick();
    chk("cnt0_254", {24'd0, c0_c}, 32'hFE);
    for (int i = 0; i < 46; i++) tick();
    chk("cnt0_sat", {24'd0, c0_c}, 32'hFF);
    sel_c = 2'd2; a_c = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("cnt2_zero_payload", {24'd0, c2_c}, 32'h00);
    chk("cnt0_hold", {24'd0, c0_c}, 32'hFF);
    sel_c = 2'd1; a_c = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("cnt1_three", {24'd0, c1_c}, 32'h03);
    chk("cnt3_idle", {24'd0, c3_c}, 32'h00);
    rst = 1'b1;
    tick();
    chk("cnt_rst", {c3_c, c2_c, c1_c, c0_c}, 32'd0);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
